// File: rtl/bht_pkg.sv
// Shared types and helpers for the branch history table predictor.
package bht_pkg;

  // Controller states: normal operation, or sweeping the table back to its init value.
  typedef enum logic {
    IDLE,
    CLEAR
  } bht_state_e;

  // Widest counter the predictor supports; sat_next works on this width.
  localparam int MAX_CNT_W = 4;

  // Saturating step of a cntW-bit counter held in the low bits of a MAX_CNT_W vector.
  // Holds at both ends instead of wrapping.
  function automatic logic [MAX_CNT_W-1:0] sat_next(
    input logic [MAX_CNT_W-1:0] cnt,
    input logic                 taken,
    input int unsigned          cntW
  );
    logic [MAX_CNT_W-1:0] maxVal;
    maxVal = MAX_CNT_W'((1 << cntW) - 1);
    if (taken) begin
      return (cnt < maxVal) ? cnt + MAX_CNT_W'(1) : cnt;
    end
    return (cnt != '0) ? cnt - MAX_CNT_W'(1) : cnt;
  endfunction

endpackage

// File: rtl/bht_predictor_if.sv
// Fetch/resolve bus of the branch predictor. The fetch/execute side is the
// master, the predictor is the slave.
interface bht_predictor_if #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 6,
  parameter int CNT_W = 2
);
  logic [PC_W-1:0]  pred_pc;
  logic             pred_taken;
  logic [CNT_W-1:0] pred_cnt;
  logic [IDX_W-1:0] pred_idx;
  logic             upd_en;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             clr_req;
  logic             busy;

  modport master (
    output pred_pc, upd_en, upd_idx, upd_taken, clr_req,
    input  pred_taken, pred_cnt, pred_idx, busy
  );

  modport slave (
    input  pred_pc, upd_en, upd_idx, upd_taken, clr_req,
    output pred_taken, pred_cnt, pred_idx, busy
  );
endinterface

// File: rtl/bht_predictor.sv
// Table of saturating counters indexed by the fetch PC, optionally hashed with
// a global history register (gshare). Combinational read, registered update,
// and a one-entry-per-cycle bulk clear engine.
module bht_predictor
  import bht_pkg::*;
#(
  parameter int ENTRIES  = 64,
  parameter int CNT_W    = 2,
  parameter int GHR_W    = 0,
  parameter int PC_W     = 32,
  parameter int INIT_CNT = 0
) (
  input logic           clk,
  input logic           reset_n,
  bht_predictor_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] INIT_VAL = CNT_W'(INIT_CNT);

  logic [CNT_W-1:0] cntTable_q [ENTRIES];
  bht_state_e       state_q;
  logic             busy_q;
  logic [IDX_W-1:0] clrPtr_q;
  logic [IDX_W-1:0] ghrPad;
  logic [IDX_W-1:0] predIdx;
  logic [CNT_W-1:0] updNext;
  logic             startClear;
  logic             doUpdate;
  logic             unusedPcBits;

  // A clear request always beats an update arriving in the same idle cycle,
  // and nothing from the resolve side is accepted while the clear runs.
  assign startClear = (state_q == IDLE) && bus.clr_req;
  assign doUpdate   = (state_q == IDLE) && bus.upd_en && !bus.clr_req;

  // Only PC bits [IDX_W+1:2] take part in the index.
  assign unusedPcBits = ^{bus.pred_pc >> (IDX_W + 2), bus.pred_pc[1:0]};

  generate
    if (GHR_W > 0) begin : gGhr
      logic [GHR_W-1:0] ghr_q;
      logic [GHR_W-1:0] ghr_d;

      // History shifts in resolved outcomes (non-speculative) and is wiped when a clear starts.
      always_comb begin
        ghr_d = ghr_q;
        if (startClear) begin
          ghr_d = '0;
        end else if (doUpdate) begin
          ghr_d = GHR_W'({ghr_q, bus.upd_taken});
        end
      end

      // History register.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          ghr_q <= '0;
        end else begin
          ghr_q <= ghr_d;
        end
      end

      assign ghrPad = IDX_W'(ghr_q);
    end else begin : gNoGhr
      assign ghrPad = '0;
    end
  endgenerate

  assign predIdx        = bus.pred_pc[IDX_W+1:2] ^ ghrPad;
  assign bus.pred_idx   = predIdx;
  assign bus.pred_cnt   = busy_q ? '0 : cntTable_q[predIdx];
  assign bus.pred_taken = !busy_q && cntTable_q[predIdx][CNT_W-1];
  assign bus.busy       = busy_q;

  // Next value of the entry being trained.
  always_comb begin
    updNext = CNT_W'(sat_next(MAX_CNT_W'(cntTable_q[bus.upd_idx]), bus.upd_taken, CNT_W));
  end

  // Clear controller: walk the pointer over every entry once, then return to idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      clrPtr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.clr_req) begin
            state_q  <= CLEAR;
            busy_q   <= 1'b1;
            clrPtr_q <= '0;
          end
        end
        CLEAR: begin
          clrPtr_q <= clrPtr_q + IDX_W'(1);
          if (clrPtr_q == IDX_W'(ENTRIES - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Counter array: reset to init, swept entry by entry during a clear, trained otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cntTable_q[i] <= INIT_VAL;
      end
    end else if (state_q == CLEAR) begin
      cntTable_q[clrPtr_q] <= INIT_VAL;
    end else if (doUpdate) begin
      cntTable_q[bus.upd_idx] <= updNext;
    end
  end

endmodule

// File: tb/tb_bht_predictor.sv
// Scoreboard bench for bht_predictor: stimulus pushes the reference model's
// expected outputs per cycle, a monitor pops and compares them mid-cycle.
module tb_bht_predictor;

  localparam int ENTRIES  = 16;
  localparam int CNT_W    = 2;
  localparam int GHR_W    = 4;
  localparam int PC_W     = 32;
  localparam int INIT_CNT = 1;
  localparam int IDX_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  typedef struct {
    int idx;
    int cnt;
    int taken;
    int busy;
  } exp_t;

  logic clk;
  logic reset_n;

  bht_predictor_if #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

  bht_predictor #(
    .ENTRIES(ENTRIES), .CNT_W(CNT_W), .GHR_W(GHR_W), .PC_W(PC_W), .INIT_CNT(INIT_CNT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // Reference model: plain array of counters, history as an integer, and a
  // countdown of how many clear cycles remain.
  int   modelTbl [ENTRIES];
  int   modelGhr;
  int   clearLeft;
  exp_t expQ [$];
  int   checks = 0;
  int   passed = 0;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkValue("pred_idx", int'(bus.pred_idx), e.idx);
    checkValue("pred_cnt", int'(bus.pred_cnt), e.cnt);
    checkValue("pred_taken", int'(bus.pred_taken), e.taken);
    checkValue("busy", int'(bus.busy), e.busy);
  endtask

  function automatic exp_t expectNow(input logic [PC_W-1:0] pc);
    exp_t e;
    e.idx = (int'(pc >> 2) % ENTRIES) ^ modelGhr;
    if (clearLeft > 0) begin
      e.cnt   = 0;
      e.taken = 0;
      e.busy  = 1;
    end else begin
      e.cnt   = modelTbl[e.idx];
      e.taken = (e.cnt >= (1 << (CNT_W - 1))) ? 1 : 0;
      e.busy  = 0;
    end
    return e;
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < ENTRIES; i++) modelTbl[i] = INIT_CNT;
    modelGhr  = 0;
    clearLeft = 0;
  endfunction

  // What the coming clock edge does to the model, given this cycle's inputs.
  function automatic void modelStep(input bit ue, input int ui, input bit ut, input bit cr);
    if (clearLeft > 0) begin
      clearLeft--;
      if (clearLeft == 0) begin
        for (int i = 0; i < ENTRIES; i++) modelTbl[i] = INIT_CNT;
      end
    end else if (cr) begin
      clearLeft = ENTRIES;
      modelGhr  = 0;
    end else if (ue) begin
      if (ut && modelTbl[ui] < CNT_MAX) modelTbl[ui]++;
      else if (!ut && modelTbl[ui] > 0) modelTbl[ui]--;
      modelGhr = ((modelGhr * 2) + (ut ? 1 : 0)) % (1 << GHR_W);
    end
  endfunction

  task automatic applyStimulus(input logic [PC_W-1:0] pc, input bit ue, input int ui,
                               input bit ut, input bit cr);
    @(posedge clk);
    #1;
    bus.pred_pc   = pc;
    bus.upd_en    = ue;
    bus.upd_idx   = IDX_W'(ui);
    bus.upd_taken = ut;
    bus.clr_req   = cr;
    expQ.push_back(expectNow(pc));
    modelStep(ue, ui, ut, cr);
  endtask

  // Asynchronous reset landing mid-cycle; outputs are checked while it is held.
  task automatic doReset();
    @(posedge clk);
    #2;
    reset_n     = 1'b0;
    bus.upd_en  = 1'b0;
    bus.clr_req = 1'b0;
    modelReset();
    #1;
    checkValue("rstBusy", int'(bus.busy), 0);
    checkValue("rstTaken", int'(bus.pred_taken), 0);
    checkValue("rstCnt", int'(bus.pred_cnt), INIT_CNT);
    expQ.push_back(expectNow(bus.pred_pc));
    @(negedge clk);
    #3;
    reset_n = 1'b1;
  endtask

  // Monitor: every mid-cycle sample is compared against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        checkOutput(expQ.pop_front());
      end
    end
  end

  // Stimulus sequence.
  initial begin
    int busyCycles;
    reset_n       = 1'b0;
    bus.pred_pc   = '0;
    bus.upd_en    = 1'b0;
    bus.upd_idx   = '0;
    bus.upd_taken = 1'b0;
    bus.clr_req   = 1'b0;
    modelReset();
    doReset();

    // Saturate entry 2 upward then downward.
    for (int i = 0; i < 5; i++) applyStimulus(32'h8, 1'b1, 2, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(32'h8, 1'b1, 2, 1'b0, 1'b0);
    applyStimulus(32'h8, 1'b1, 2, 1'b1, 1'b0);

    // Read and update the same entry in one cycle: read sees the old value.
    applyStimulus(32'((2 ^ modelGhr) << 2), 1'b1, 2, 1'b1, 1'b0);
    applyStimulus(32'((2 ^ modelGhr) << 2), 1'b0, 0, 1'b0, 1'b0);

    // Gshare indexing from a known history of taken,taken,not-taken,taken.
    doReset();
    applyStimulus(32'h0, 1'b1, 0, 1'b1, 1'b0);
    applyStimulus(32'h0, 1'b1, 0, 1'b1, 1'b0);
    applyStimulus(32'h0, 1'b1, 0, 1'b0, 1'b0);
    applyStimulus(32'h0, 1'b1, 0, 1'b1, 1'b0);
    applyStimulus(32'h0, 1'b0, 0, 1'b0, 1'b0);
    #2 checkValue("gshareIdxPc0", int'(bus.pred_idx), 13);
    applyStimulus(32'h34, 1'b0, 0, 1'b0, 1'b0);
    #2 checkValue("gshareIdxPc34", int'(bus.pred_idx), 0);

    // Train a few entries, then clear with a same-cycle update to entry 3.
    for (int i = 0; i < 12; i++) applyStimulus($urandom, 1'b1, i % 6, 1'b1, 1'b0);
    applyStimulus($urandom, 1'b1, 3, 1'b1, 1'b1);
    busyCycles = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus($urandom, (i < 16) ? 1'($urandom) : 1'b0, $urandom_range(0, ENTRIES - 1),
                    1'($urandom), (i == 6));
      #2;
      if (bus.busy) busyCycles++;
      if (bus.busy && bus.pred_taken) checkValue("takenWhileBusy", 1, 0);
    end
    checkValue("busyLength", busyCycles, ENTRIES);
    applyStimulus(32'h0000_000C, 1'b0, 0, 1'b0, 1'b0);
    #2 checkValue("clrBeatsUpdate", int'(bus.pred_cnt), INIT_CNT);
    for (int e = 0; e < ENTRIES; e++) applyStimulus(32'(e << 2), 1'b0, 0, 1'b0, 1'b0);

    // Reset landing five cycles into a clear.
    for (int i = 0; i < 8; i++) applyStimulus($urandom, 1'b1, i, 1'b1, 1'b0);
    applyStimulus($urandom, 1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus($urandom, 1'b0, 0, 1'b0, 1'b0);
    doReset();
    for (int e = 0; e < ENTRIES; e++) applyStimulus(32'(e << 2), 1'b0, 0, 1'b0, 1'b0);

    // Randomised traffic with occasional clears.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom, ($urandom_range(0, 99) < 60), $urandom_range(0, ENTRIES - 1),
                    ($urandom_range(0, 99) < 65), ($urandom_range(0, 99) < 2));
    end
    applyStimulus($urandom, 1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    checkValue("scoreboardDrained", expQ.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bht_predictor.md
Name: bht_predictor

Overview:
- Parametrised branch history table (BHT) of N-bit saturating counters, indexed by PC, optionally XOR-ed with a global history register (gshare).
- Generalises the single 2-bit counter to a table of counters.
- Sits in the fetch stage: combinational prediction for the fetch PC; update from the execute/branch-resolution stage.
- Adds a sequential bulk-clear engine for context switch / fence.

Parameters:
- ENTRIES, 64: number of counters; power of two, >= 2. IDX_W = $clog2(ENTRIES).
- CNT_W, 2: counter width, 1..4. Prediction is taken when the counter MSB is 1.
- GHR_W, 0: global history length, 0..IDX_W. 0 = pure bimodal.
- PC_W, 32: PC width; must be >= IDX_W+2.
- INIT_CNT, 0: counter value after reset and after clear; must fit in CNT_W bits.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- pred_pc  in  PC_W  fetch PC to predict.
- pred_taken  out  1  prediction for pred_pc; combinational.
- pred_cnt  out  CNT_W  raw counter value read for pred_pc.
- pred_idx  out  IDX_W  index used for the read; the pipeline carries it to upd_idx.
- upd_en  in  1  branch resolved this cycle.
- upd_idx  in  IDX_W  entry to update.
- upd_taken  in  1  actual branch outcome.
- clr_req  in  1  single-cycle pulse: start bulk clear.
- busy  out  1  clear in progress.

Behaviour:
- Reset (async, reset_n low): all counters = INIT_CNT; GHR = 0; FSM = IDLE; busy = 0.
  - Outputs during reset follow the combinational rules: pred_taken = INIT_CNT[CNT_W-1], pred_cnt = INIT_CNT.
- Index computation:
  - pred_idx = pred_pc[IDX_W+1:2] XOR {zero pad, ghr[GHR_W-1:0]}.
  - GHR_W = 0: no XOR term; no GHR flops.
- Read path (IDLE):
  - pred_cnt = table[pred_idx]; pred_taken = pred_cnt[CNT_W-1].
  - Zero latency, no handshake.
- Update (upd_en=1, IDLE), registered, visible the next cycle:
  - upd_taken=1 and counter < 2^CNT_W-1: increment.
  - upd_taken=0 and counter > 0: decrement.
  - At a saturation boundary the counter holds; it never wraps.
  - GHR: ghr <= {ghr[GHR_W-2:0], upd_taken}. Non-speculative; GHR_W=1 is a single bit.
- Simultaneous read and update of the same index: no bypass. The read returns the pre-update value.
- FSM states IDLE, CLEAR:
  - IDLE -> CLEAR when clr_req=1. clr_ptr <= 0; GHR <= 0 in the same edge.
  - CLEAR: each cycle table[clr_ptr] <= INIT_CNT, clr_ptr++.
  - CLEAR -> IDLE on the cycle clr_ptr == ENTRIES-1 is written. The clear takes exactly ENTRIES cycles.
  - busy = 1 iff state == CLEAR, registered.
  - While busy: pred_taken = 0, pred_cnt = 0. pred_idx is still computed normally.
  - While busy, upd_en is ignored: no counter update, no GHR shift.
  - clr_req while busy is ignored; the clear does not restart.
  - clr_req and upd_en in the same IDLE cycle: clear wins; the update is dropped.
- Reset asserted mid-CLEAR: immediate return to the reset state; the clear is not resumed.

Decomposition:
- Shared package bht_pkg:
  - function sat_next(cnt, taken), parametrised by CNT_W via a localparam pattern or width-generic implementation.
  - typedef enum logic {IDLE, CLEAR} bht_state_e.
- No sub-module: the counter array, index logic and FSM live in one module, which keeps the table a single flop array.

Test Plan:
- Saturation. ENTRIES=16, CNT_W=2, GHR_W=0, INIT_CNT=0. pred_pc=0x8; 4× upd_en, upd_idx=2, upd_taken=1.
  -> pred_cnt 0,1,2,3,3; pred_taken goes 1 after the 2nd update. Then 4× taken=0 -> 3,2,1,0,0.
- Read/update collision. Counter at 1; same cycle pred_pc indexes entry 2 and upd_en increments entry 2.
  -> pred_cnt=1 that cycle, 2 the next cycle.
- Gshare indexing. GHR_W=4; updates taken,taken,not-taken,taken on idx 0 -> ghr=4'b1101; pred_pc=0x0.
  -> pred_idx=13. pred_pc=0x34 -> pred_idx = 13 XOR 13 = 0.
- Bulk clear. Several counters nonzero, INIT_CNT=1; pulse clr_req.
  -> busy=1 for exactly 16 cycles, pred_taken=0 throughout, upd_en during busy has no effect.
  -> After busy falls, every entry reads pred_cnt=1 and ghr=0.
- Clear vs update priority. clr_req and upd_en (idx 3, taken) in the same cycle.
  -> Entry 3 = INIT_CNT after the clear; a clr_req mid-clear does not extend busy beyond 16 cycles.
- Async reset mid-clear. Drop reset_n 5 cycles into CLEAR.
  -> busy=0 immediately; all entries INIT_CNT; ghr=0; pred_taken=INIT_CNT MSB.
